// File: rtl/ghost_scheduler_if.sv
// rtl/ghost_scheduler_if.sv - handshake to the shared ghost direction-calculation unit
interface ghost_scheduler_if;
    logic        calc_req;
    logic [10:0] calc_ghost_x;
    logic [9:0]  calc_ghost_y;
    logic [10:0] calc_target_x;
    logic [9:0]  calc_target_y;
    logic [3:0]  calc_prev_dir;
    logic        calc_ready;
    logic [3:0]  calc_dir;

    modport master (
        output calc_req, calc_ghost_x, calc_ghost_y, calc_target_x, calc_target_y, calc_prev_dir,
        input  calc_ready, calc_dir
    );

    modport slave (
        input  calc_req, calc_ghost_x, calc_ghost_y, calc_target_x, calc_target_y, calc_prev_dir,
        output calc_ready, calc_dir
    );
endinterface

// File: rtl/ghost_scheduler.sv
// rtl/ghost_scheduler.sv - per-frame scheduler sharing one direction unit across four ghosts
module ghost_scheduler #(
    parameter int NUM_GHOSTS    = 4,
    parameter int SCATTER_TICKS = 7,
    parameter int CHASE_TICKS   = 20,
    parameter int TIMEOUT       = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic [43:0]              ghost_pos_x,
    input  logic [39:0]              ghost_pos_y,
    input  logic [10:0]              pacman_pos_x,
    input  logic [9:0]               pacman_pos_y,
    ghost_scheduler_if.master        calc_if,
    output logic [15:0]              ghost_dir,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     chase_mode,
    output logic                     tick_overrun,
    output logic                     calc_timeout
);

    localparam int MW = (SCATTER_TICKS + CHASE_TICKS > 1) ? $clog2(SCATTER_TICKS + CHASE_TICKS) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0]    IDX_LAST   = 2'(NUM_GHOSTS - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [MW-1:0] MODE_LAST  = MW'(SCATTER_TICKS + CHASE_TICKS - 1);
    localparam logic [MW-1:0] MODE_SPLIT = MW'(SCATTER_TICKS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [MW-1:0] mode_cnt_q, mode_cnt_d;
    logic          mode_q, mode_d;
    logic [43:0]   snap_gx_q, snap_gx_d;
    logic [39:0]   snap_gy_q, snap_gy_d;
    logic [10:0]   snap_px_q, snap_px_d;
    logic [9:0]    snap_py_q, snap_py_d;
    logic [15:0]   dir_q, dir_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic          advance;
    logic          dir_ok;
    logic          serving;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            wait_q     <= '0;
            mode_cnt_q <= '0;
            mode_q     <= 1'b0;
            snap_gx_q  <= '0;
            snap_gy_q  <= '0;
            snap_px_q  <= '0;
            snap_py_q  <= '0;
            dir_q      <= '0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            mode_cnt_q <= mode_cnt_d;
            mode_q     <= mode_d;
            snap_gx_q  <= snap_gx_d;
            snap_gy_q  <= snap_gy_d;
            snap_px_q  <= snap_px_d;
            snap_py_q  <= snap_py_d;
            dir_q      <= dir_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        mode_cnt_d = mode_cnt_q;
        mode_d     = mode_q;
        snap_gx_d  = snap_gx_q;
        snap_gy_d  = snap_gy_q;
        snap_px_d  = snap_px_q;
        snap_py_d  = snap_py_q;
        dir_d      = dir_q;
        overrun_d  = overrun_q;
        timeout_d  = timeout_q;
        advance    = 1'b0;
        dir_ok     = (calc_if.calc_dir != 4'd0) &&
                     ((calc_if.calc_dir & (calc_if.calc_dir - 4'd1)) == 4'd0);

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    idx_d      = '0;
                    snap_gx_d  = ghost_pos_x;
                    snap_gy_d  = ghost_pos_y;
                    snap_px_d  = pacman_pos_x;
                    snap_py_d  = pacman_pos_y;
                    mode_d     = (mode_cnt_q >= MODE_SPLIT);
                    mode_cnt_d = (mode_cnt_q == MODE_LAST) ? '0 : mode_cnt_q + 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Malformed (non one-hot) results are dropped; the ghost keeps its heading.
                if (calc_if.calc_ready) begin
                    if (dir_ok) begin
                        dir_d[{idx_q, 2'b00} +: 4] = calc_if.calc_dir;
                    end
                    advance = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    advance   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            if (idx_q == IDX_LAST) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_ISSUE;
            end
        end

        if (tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Request fields are zero outside ISSUE/WAIT so idle and reset present a clean bus.
    assign serving = (state_q == S_ISSUE) || (state_q == S_WAIT);

    always_comb begin
        calc_if.calc_req      = (state_q == S_ISSUE);
        calc_if.calc_ghost_x  = '0;
        calc_if.calc_ghost_y  = '0;
        calc_if.calc_target_x = '0;
        calc_if.calc_target_y = '0;
        calc_if.calc_prev_dir = '0;
        if (serving) begin
            calc_if.calc_ghost_x  = snap_gx_q[int'(idx_q) * 11 +: 11];
            calc_if.calc_ghost_y  = snap_gy_q[int'(idx_q) * 10 +: 10];
            calc_if.calc_prev_dir = dir_q[{idx_q, 2'b00} +: 4];
            if (mode_q) begin
                calc_if.calc_target_x = snap_px_q;
                calc_if.calc_target_y = snap_py_q;
            end else begin
                calc_if.calc_target_x = idx_q[0] ? 11'd0 : 11'd639;
                calc_if.calc_target_y = idx_q[1] ? 10'd479 : 10'd0;
            end
        end
    end

    assign ghost_dir    = dir_q;
    assign busy         = (state_q != S_IDLE);
    assign frame_done   = (state_q == S_DONE);
    assign chase_mode   = mode_q;
    assign tick_overrun = overrun_q;
    assign calc_timeout = timeout_q;

endmodule

// File: tb/tb_ghost_scheduler.sv
// tb/tb_ghost_scheduler.sv - directed self-checking bench for ghost_scheduler
module tb_ghost_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [43:0] ghost_pos_x;
    logic [39:0] ghost_pos_y;
    logic [10:0] pacman_pos_x;
    logic [9:0]  pacman_pos_y;
    logic [15:0] ghost_dir;
    logic        busy, frame_done, chase_mode, tick_overrun, calc_timeout;

    ghost_scheduler_if calc_if ();

    ghost_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .ghost_pos_x  (ghost_pos_x),
        .ghost_pos_y  (ghost_pos_y),
        .pacman_pos_x (pacman_pos_x),
        .pacman_pos_y (pacman_pos_y),
        .calc_if      (calc_if),
        .ghost_dir    (ghost_dir),
        .busy         (busy),
        .frame_done   (frame_done),
        .chase_mode   (chase_mode),
        .tick_overrun (tick_overrun),
        .calc_timeout (calc_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int          req_at [4];
    logic [3:0]  prev_at [4];
    logic [10:0] gx_at [4];
    logic [9:0]  gy_at [4];
    logic [10:0] tx_at [4];
    logic [9:0]  ty_at [4];
    logic        mode_at;
    int          done_at;

    logic [10:0] exp_gx [4] = '{11'd100, 11'd200, 11'd300, 11'd400};
    logic [9:0]  exp_gy [4] = '{10'd10, 10'd20, 10'd30, 10'd40};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick = 1'b0;
        calc_if.calc_ready = 1'b0;
        calc_if.calc_dir = 4'd0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Drives one frame: tick, then answers ghost g one cycle after its request when answer[g] is set.
    task automatic drive_frame(input logic [15:0] dirs, input logic [3:0] answer);
        int t;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        t = 1;
        for (int g = 0; g < 4; g++) begin
            while (!calc_if.calc_req && t < 200) begin
                cyc();
                t++;
            end
            req_at[g]  = calc_if.calc_req ? t : -1;
            prev_at[g] = calc_if.calc_prev_dir;
            gx_at[g]   = calc_if.calc_ghost_x;
            gy_at[g]   = calc_if.calc_ghost_y;
            tx_at[g]   = calc_if.calc_target_x;
            ty_at[g]   = calc_if.calc_target_y;
            if (g == 0) mode_at = chase_mode;
            cyc();
            t++;
            if (answer[g]) begin
                calc_if.calc_ready = 1'b1;
                calc_if.calc_dir   = dirs[4*g +: 4];
                cyc();
                t++;
                calc_if.calc_ready = 1'b0;
                calc_if.calc_dir   = 4'd0;
            end
        end
        while (!frame_done && t < 300) begin
            cyc();
            t++;
        end
        done_at = frame_done ? t : -1;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (calc_if.calc_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", calc_if.calc_req); end
        n_cmp++; if (ghost_dir !== 16'h0000) begin n_err++; $display("FAIL reset_dir got %h want 0000", ghost_dir); end
        n_cmp++; if ({frame_done, chase_mode, tick_overrun, calc_timeout} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got %b want 0000", {frame_done, chase_mode, tick_overrun, calc_timeout}); end
        n_cmp++; if (calc_if.calc_target_x !== 11'd0 || calc_if.calc_ghost_x !== 11'd0) begin
            n_err++; $display("FAIL reset_calc got %0d/%0d want 0/0", calc_if.calc_target_x, calc_if.calc_ghost_x); end
    endtask

    task automatic test_basic_frame();
        do_reset();
        drive_frame(16'h8421, 4'hF);
        for (int g = 0; g < 4; g++) begin
            n_cmp++; if (req_at[g] !== 1 + 2*g) begin n_err++; $display("FAIL basic_req_time g%0d got %0d want %0d", g, req_at[g], 1 + 2*g); end
            n_cmp++; if (prev_at[g] !== 4'b0000) begin n_err++; $display("FAIL basic_prev g%0d got %b want 0000", g, prev_at[g]); end
            n_cmp++; if (gx_at[g] !== exp_gx[g] || gy_at[g] !== exp_gy[g]) begin
                n_err++; $display("FAIL basic_pos g%0d got %0d,%0d want %0d,%0d", g, gx_at[g], gy_at[g], exp_gx[g], exp_gy[g]); end
        end
        n_cmp++; if (done_at !== 9) begin n_err++; $display("FAIL basic_done_time got %0d want 9", done_at); end
        n_cmp++; if (ghost_dir !== 16'h8421) begin n_err++; $display("FAIL basic_dir got %h want 8421", ghost_dir); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle got %b want 0", busy); end
        n_cmp++; if (calc_timeout !== 1'b0 || tick_overrun !== 1'b0) begin
            n_err++; $display("FAIL basic_sticky got %b%b want 00", calc_timeout, tick_overrun); end
    endtask

    task automatic test_bad_dir();
        drive_frame(16'h2183, 4'hF);
        n_cmp++; if (ghost_dir !== 16'h2181) begin n_err++; $display("FAIL baddir_dir got %h want 2181", ghost_dir); end
        n_cmp++; if (done_at !== 9) begin n_err++; $display("FAIL baddir_done got %0d want 9", done_at); end
        n_cmp++; if (prev_at[0] !== 4'b0001 || prev_at[3] !== 4'b1000) begin
            n_err++; $display("FAIL baddir_prev got %b,%b want 0001,1000", prev_at[0], prev_at[3]); end
    endtask

    task automatic test_timeout();
        do_reset();
        drive_frame(16'h8421, 4'b1101);
        n_cmp++; if (req_at[1] !== 3) begin n_err++; $display("FAIL to_req1 got %0d want 3", req_at[1]); end
        n_cmp++; if (req_at[2] !== 19) begin n_err++; $display("FAIL to_req2 got %0d want 19", req_at[2]); end
        n_cmp++; if (done_at !== 23) begin n_err++; $display("FAIL to_done got %0d want 23", done_at); end
        n_cmp++; if (calc_timeout !== 1'b1) begin n_err++; $display("FAIL to_flag got %b want 1", calc_timeout); end
        n_cmp++; if (ghost_dir !== 16'h8401) begin n_err++; $display("FAIL to_dir got %h want 8401", ghost_dir); end
    endtask

    task automatic test_overrun();
        do_reset();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        tick = 1'b1;
        calc_if.calc_ready = 1'b1;
        calc_if.calc_dir = 4'b0001;
        cyc();
        tick = 1'b0;
        calc_if.calc_ready = 1'b0;
        n_cmp++; if (tick_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag got %b want 1", tick_overrun); end
        n_cmp++; if (calc_if.calc_req !== 1'b1 || calc_if.calc_ghost_x !== 11'd200) begin
            n_err++; $display("FAIL ovr_norestart got req %b x %0d want 1 200", calc_if.calc_req, calc_if.calc_ghost_x); end
        for (int g = 1; g < 4; g++) begin
            cyc();
            calc_if.calc_ready = 1'b1;
            calc_if.calc_dir = 4'b0010;
            cyc();
            calc_if.calc_ready = 1'b0;
        end
        n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL ovr_done got %b want 1", frame_done); end
        cyc();
        for (int f = 2; f <= 8; f++) begin
            drive_frame(16'h1111, 4'hF);
            if (f == 7) begin
                n_cmp++; if (mode_at !== 1'b0) begin n_err++; $display("FAIL ovr_mode7 got %b want 0", mode_at); end
            end
            if (f == 8) begin
                n_cmp++; if (mode_at !== 1'b1) begin n_err++; $display("FAIL ovr_mode8 got %b want 1", mode_at); end
            end
        end
    endtask

    task automatic test_mode_sequence();
        logic exp_mode;
        do_reset();
        for (int f = 1; f <= 28; f++) begin
            drive_frame(16'h1111, 4'hF);
            exp_mode = (f >= 8 && f <= 27);
            n_cmp++; if (mode_at !== exp_mode) begin n_err++; $display("FAIL mode_f%0d got %b want %b", f, mode_at, exp_mode); end
            if (f == 1) begin
                for (int g = 0; g < 4; g++) begin
                    n_cmp++;
                    if (tx_at[g] !== ((g % 2 == 0) ? 11'd639 : 11'd0) || ty_at[g] !== ((g >= 2) ? 10'd479 : 10'd0)) begin
                        n_err++; $display("FAIL scatter_tgt g%0d got %0d,%0d", g, tx_at[g], ty_at[g]); end
                end
            end
            if (f == 8) begin
                for (int g = 0; g < 4; g++) begin
                    n_cmp++; if (tx_at[g] !== 11'd321 || ty_at[g] !== 10'd123) begin
                        n_err++; $display("FAIL chase_tgt g%0d got %0d,%0d want 321,123", g, tx_at[g], ty_at[g]); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        tick = 1'b1;
        calc_if.calc_ready = 1'b1;
        calc_if.calc_dir = 4'b0001;
        cyc();
        tick = 1'b0;
        calc_if.calc_ready = 1'b0;
        cyc();
        calc_if.calc_ready = 1'b1;
        calc_if.calc_dir = 4'b0010;
        cyc();
        calc_if.calc_ready = 1'b0;
        cyc();
        n_cmp++; if (ghost_dir !== 16'h0021 || tick_overrun !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL rmid_pre got dir %h ovr %b busy %b want 0021 1 1", ghost_dir, tick_overrun, busy); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++; if ({busy, calc_if.calc_req, frame_done, chase_mode, tick_overrun, calc_timeout} !== 6'b0) begin
            n_err++; $display("FAIL rmid_flags got %b want 000000", {busy, calc_if.calc_req, frame_done, chase_mode, tick_overrun, calc_timeout}); end
        n_cmp++; if (ghost_dir !== 16'h0000) begin n_err++; $display("FAIL rmid_dir got %h want 0000", ghost_dir); end
        n_cmp++; if (calc_if.calc_ghost_x !== 11'd0 || calc_if.calc_ghost_y !== 10'd0 || calc_if.calc_prev_dir !== 4'd0) begin
            n_err++; $display("FAIL rmid_calc got %0d,%0d,%b want 0,0,0000", calc_if.calc_ghost_x, calc_if.calc_ghost_y, calc_if.calc_prev_dir); end
        calc_if.calc_ready = 1'b1;
        calc_if.calc_dir = 4'b0100;
        cyc();
        calc_if.calc_ready = 1'b0;
        n_cmp++; if (ghost_dir !== 16'h0000 || busy !== 1'b0) begin
            n_err++; $display("FAIL rmid_late got dir %h busy %b want 0000 0", ghost_dir, busy); end
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        calc_if.calc_ready = 1'b0;
        calc_if.calc_dir = 4'd0;
        ghost_pos_x = {11'd400, 11'd300, 11'd200, 11'd100};
        ghost_pos_y = {10'd40, 10'd30, 10'd20, 10'd10};
        pacman_pos_x = 11'd321;
        pacman_pos_y = 10'd123;
        test_reset();
        test_basic_frame();
        test_bad_dir();
        test_timeout();
        test_overrun();
        test_mode_sequence();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
